// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_pkg                                                   |
// | Purpose  : Shared constants and types for the VGA framebuffer        |
// |            scan-out path (framebuffer geometry, pipeline latency,    |
// |            12-bit colour type and the reset palette ramp).           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int FB_W        = 160;  // framebuffer width in pixels
  localparam int FB_H        = 120;  // framebuffer height in pixels
  localparam int FB_SCALE_SH = 2;    // each framebuffer pixel is 4x4 screen pixels
  localparam int PIPE_LAT    = 3;    // coordinate-in to colour-out latency

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Grayscale value loaded into palette entry i on reset.
  function automatic rgb12_t ramp_entry(input logic [3:0] i);
    rgb12_t c;
    c.r = i;
    c.g = i;
    c.b = i;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_palette.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_palette                                               |
// | Purpose  : 16 x 12-bit colour lookup table. One synchronous write    |
// |            port, one asynchronous read port. Reset reloads a         |
// |            grayscale ramp. A read of an entry being written in the   |
// |            same cycle sees the old contents.                         |
// | Ports    : clk, reset       - clock, sync active-high reset          |
// |            we, widx, wdata  - write strobe, entry, value             |
// |            ridx, rdata      - read index, colour (combinational)     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module vga_palette
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] widx,
  input  rgb12_t     wdata,
  input  logic [3:0] ridx,
  output rgb12_t     rdata
);

  rgb12_t mem [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= ramp_entry(4'(i));
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule
`default_nettype wire

// File: rtl/vga_fb_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_fb_reader                                             |
// | Purpose  : Framebuffer scan-out. Turns the sync generator's pixel    |
// |            coordinate into a read address for a 4x-downscaled        |
// |            indexed framebuffer, maps the returned index through the  |
// |            palette and delays HS/VS so colour and sync leave aligned.|
// | Ports    : clk, reset               - pixel clock, sync reset        |
// |            x, y, video_on           - coordinate and visible flag    |
// |            hsync_in, vsync_in       - raw active-low syncs           |
// |            fb_addr / fb_data        - framebuffer read port          |
// |            pal_we, pal_idx, pal_data- palette write port             |
// |            HS, VS, VGA_R/G/B        - aligned outputs                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module vga_fb_reader #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [3:0]        fb_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_data,
  output logic              HS,
  output logic              VS,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B
);

  import vga_pkg::*;

  localparam int CRD_W = 10 - FB_SCALE_SH;

  // ---------------------------------------------------------------- stage 1
  logic [CRD_W-1:0]  col;
  logic [CRD_W-1:0]  row;
  logic              in_fb;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_next;

  assign col = x[9:FB_SCALE_SH];
  assign row = y[9:FB_SCALE_SH];

  // Coordinates outside the framebuffer never occur with video_on set for
  // a valid timing, but gating on them keeps the address in range anyway.
  assign in_fb = video_on && (int'(col) < FB_W) && (int'(row) < FB_H);

  generate
    if (FB_W == 160) begin : g_mul_160
      // row*160 = row*128 + row*32
      assign row_base = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5);
    end else begin : g_mul_generic
      assign row_base = ADDR_W'(row * FB_W);
    end
  endgenerate

  assign addr_next = in_fb ? (row_base + ADDR_W'(col)) : '0;

  // ---------------------------------------------------------------- stage 3
  rgb12_t pal_rd;
  rgb12_t rgb_q;

  vga_palette u_palette (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we),
    .widx  (pal_idx),
    .wdata (rgb12_t'(pal_data)),
    .ridx  (fb_data),
    .rdata (pal_rd)
  );

  // Sync delay lines are the full latency long. The visible flag only needs
  // to reach stage 2 (alongside fb_data); the colour register itself is its
  // third stage, forced to black when the pixel is blanked.
  logic [PIPE_LAT-1:0] hs_pipe;
  logic [PIPE_LAT-1:0] vs_pipe;
  logic [PIPE_LAT-2:0] vo_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_addr <= '0;
      hs_pipe <= '1;
      vs_pipe <= '1;
      vo_pipe <= '0;
      rgb_q   <= '0;
    end else begin
      fb_addr <= addr_next;
      hs_pipe <= {hs_pipe[PIPE_LAT-2:0], hsync_in};
      vs_pipe <= {vs_pipe[PIPE_LAT-2:0], vsync_in};
      vo_pipe <= {vo_pipe[PIPE_LAT-3:0], video_on};
      rgb_q   <= vo_pipe[PIPE_LAT-2] ? pal_rd : '0;
    end
  end

  assign HS    = hs_pipe[PIPE_LAT-1];
  assign VS    = vs_pipe[PIPE_LAT-1];
  assign VGA_R = rgb_q.r;
  assign VGA_G = rgb_q.g;
  assign VGA_B = rgb_q.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_vga_fb_reader                                          |
// | Purpose  : Self-checking bench for vga_fb_reader: directed scenarios |
// |            followed by randomized traffic against a cycle-history    |
// |            reference model and a synchronous framebuffer model.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_vga_fb_reader;

  localparam int ADDR_W = 15;
  localparam int NCYC   = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        x = '0;
  logic [9:0]        y = '0;
  logic              video_on = 1'b0;
  logic              hsync_in = 1'b1;
  logic              vsync_in = 1'b1;
  logic [ADDR_W-1:0] fb_addr;
  logic [3:0]        fb_data = '0;
  logic              pal_we = 1'b0;
  logic [3:0]        pal_idx = '0;
  logic [11:0]       pal_data = '0;
  logic              HS, VS;
  logic [3:0]        VGA_R, VGA_G, VGA_B;

  vga_fb_reader #(.FB_W(160), .FB_H(120), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .y        (y),
    .video_on (video_on),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .pal_we   (pal_we),
    .pal_idx  (pal_idx),
    .pal_data (pal_data),
    .HS       (HS),
    .VS       (VS),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B)
  );

  always #20 clk = ~clk;

  // Framebuffer: index returned one cycle after the address.
  logic [3:0] fbmem [1<<ADDR_W];
  always @(posedge clk) fb_data <= fbmem[fb_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-edge history of what was applied, and the index the memory handed out.
  bit         h_rst [NCYC];
  bit         h_vo  [NCYC];
  bit         h_hs  [NCYC];
  bit         h_vs  [NCYC];
  int         h_addr[NCYC];
  logic [3:0] h_mem [NCYC];
  logic [11:0] pal_m [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit rst_at(input int k);
    return (k < 0) ? 1'b1 : h_rst[k];
  endfunction

  function automatic logic [11:0] rgb_now();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  // Apply one cycle of inputs, then compare every output against the model.
  task automatic step(input bit r, input bit vo, input int xx, input int yy,
                      input bit hs, input bit vs,
                      input bit we, input int idx, input int dat);
    bit          busy;
    logic [11:0] exp_rgb;
    @(negedge clk);
    reset    = r;
    video_on = vo;
    x        = 10'(xx);
    y        = 10'(yy);
    hsync_in = hs;
    vsync_in = vs;
    pal_we   = we;
    pal_idx  = 4'(idx);
    pal_data = 12'(dat);
    h_rst[cyc]  = r;
    h_vo[cyc]   = vo;
    h_hs[cyc]   = hs;
    h_vs[cyc]   = vs;
    h_addr[cyc] = (r || !vo) ? 0 : (yy / 4) * 160 + (xx / 4);
    h_mem[cyc]  = (cyc >= 1) ? fbmem[h_addr[cyc-1]] : 4'd0;
    @(posedge clk);
    #1;
    busy = rst_at(cyc) || rst_at(cyc-1) || rst_at(cyc-2);
    if (busy || !h_vo[cyc-2]) exp_rgb = 12'h000;
    else                      exp_rgb = pal_m[h_mem[cyc-1]];
    check("fb_addr", 32'(fb_addr), 32'(h_addr[cyc]));
    check("HS", 32'(HS), busy ? 32'd1 : 32'(h_hs[cyc-2]));
    check("VS", 32'(VS), busy ? 32'd1 : 32'(h_vs[cyc-2]));
    check("rgb", 32'(rgb_now()), 32'(exp_rgb));
    // Palette state after this edge.
    if (r) begin
      for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
    end else if (we) begin
      pal_m[idx] = 12'(dat);
    end
    cyc++;
  endtask

  task automatic fill_mem(input int v);
    for (int i = 0; i < (1 << ADDR_W); i++) fbmem[i] = 4'(v);
  endtask

  // A visible pixel with no palette write.
  task automatic pix(input int xx, input int yy, input bit hs);
    step(1'b0, 1'b1, xx, yy, hs, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
    fill_mem(5);

    // Reset with arbitrary inputs.
    step(1'b1, 1'b1, 300, 200, 1'b0, 1'b0, 1'b1, 5, 12'hABC);
    step(1'b1, 1'b1, 301, 200, 1'b0, 1'b0, 1'b1, 5, 12'hABC);
    check("rst_HS", 32'(HS), 32'd1);
    check("rst_VS", 32'(VS), 32'd1);
    check("rst_rgb", 32'(rgb_now()), 32'h000);
    check("rst_addr", 32'(fb_addr), 32'd0);

    // Address mapping and the ramp value of entry 5.
    pix(13, 9, 1'b1);
    check("addr_13_9", 32'(fb_addr), 32'd323);
    pix(639, 479, 1'b1);
    check("addr_639_479", 32'(fb_addr), 32'd19199);
    pix(100, 100, 1'b1);
    check("pal5_ramp", 32'(rgb_now()), 32'h555);

    // Latency / alignment: HS falls three cycles after hsync_in.
    fill_mem(7);
    for (int i = 0; i < 4; i++) pix(20 + i, 40, 1'b1);
    pix(24, 40, 1'b0);
    check("hs_lat_n1", 32'(HS), 32'd1);
    pix(25, 40, 1'b0);
    check("hs_lat_n2", 32'(HS), 32'd1);
    pix(26, 40, 1'b0);
    check("hs_lat_n3", 32'(HS), 32'd0);
    check("hs_lat_rgb", 32'(rgb_now()), 32'h777);

    // Blanking.
    step(1'b0, 1'b0, 700, 40, 1'b1, 1'b1, 1'b0, 0, 0);
    check("blank_addr", 32'(fb_addr), 32'd0);
    step(1'b0, 1'b0, 701, 40, 1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 702, 40, 1'b1, 1'b1, 1'b0, 0, 0);
    check("blank_rgb", 32'(rgb_now()), 32'h000);

    // Palette write coinciding with a lookup of the same entry.
    fill_mem(3);
    for (int i = 0; i < 4; i++) pix(i * 4, 60, 1'b1);
    step(1'b0, 1'b1, 16, 60, 1'b1, 1'b1, 1'b1, 3, 12'hF00);
    check("palwr_old", 32'(rgb_now()), 32'h333);
    pix(20, 60, 1'b1);
    check("palwr_new", 32'(rgb_now()), 32'hF00);

    // Mid-frame reset restores the ramp and blanks three outputs.
    fill_mem(7);
    step(1'b0, 1'b1, 0, 80, 1'b0, 1'b1, 1'b1, 7, 12'hABC);
    for (int i = 1; i < 5; i++) pix(i, 80, 1'b0);
    check("pre_rst_rgb", 32'(rgb_now()), 32'hABC);
    step(1'b1, 1'b1, 5, 80, 1'b0, 1'b0, 1'b0, 0, 0);
    check("mrst0_rgb", 32'(rgb_now()), 32'h000);
    check("mrst0_HS", 32'(HS), 32'd1);
    pix(6, 80, 1'b0);
    check("mrst1_rgb", 32'(rgb_now()), 32'h000);
    check("mrst1_HS", 32'(HS), 32'd1);
    pix(7, 80, 1'b0);
    check("mrst2_rgb", 32'(rgb_now()), 32'h000);
    check("mrst2_VS", 32'(VS), 32'd1);
    pix(8, 80, 1'b0);
    check("mrst3_rgb", 32'(rgb_now()), 32'h777);
    check("mrst3_HS", 32'(HS), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < (1 << ADDR_W); i++) fbmem[i] = 4'($urandom_range(0, 15));
    for (int n = 0; n < 2500; n++) begin
      int xx, yy;
      bit vo;
      xx = $urandom_range(0, 799);
      yy = $urandom_range(0, 524);
      vo = (xx < 640) && (yy < 480) && ($urandom_range(0, 15) != 0);
      step($urandom_range(0, 63) == 0, vo, xx, yy,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 4095));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fb_reader.md
# vga_fb_reader

Framebuffer scan-out stage between the sync generator and the VGA pins, clocked by the 25 MHz pixel clock. It converts the current pixel coordinate into a read address for a 160x120, 4-bit-indexed framebuffer, with each framebuffer pixel covering a 4x4 block on screen. It maps the returned index through a writable 16-entry 12-bit palette. It delays HS/VS/video_on so that colour and sync leave the block aligned.

## Interface
- `FB_W`, default 160: framebuffer width in pixels.
- `FB_H`, default 120: framebuffer height in pixels.
- `ADDR_W`, default 15: framebuffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.

- `clk` in 1: pixel clock (25 MHz). The block has one clock.
- `reset` in 1: synchronous, active-high.
- `x` in 10: current pixel column from the sync generator, range 0..799.
- `y` in 10: current pixel row, range 0..524.
- `video_on` in 1: visible-area flag, aligned with `x`/`y`.
- `hsync_in` in 1: raw HS from the sync generator, active-low.
- `vsync_in` in 1: raw VS, active-low.
- `fb_addr` out ADDR_W: framebuffer read address.
- `fb_data` in 4: palette index returned by the framebuffer, exactly one cycle after `fb_addr`.
- `pal_we` in 1: palette write strobe.
- `pal_idx` in 4: palette entry to write.
- `pal_data` in 12: entry value, {R[3:0],G[3:0],B[3:0]}.
- `HS` out 1: aligned HS.
- `VS` out 1: aligned VS.
- `VGA_R` out 4: aligned red.
- `VGA_G` out 4: aligned green.
- `VGA_B` out 4: aligned blue.

## Operation
- **Stage 1 (address).** Register `fb_addr` = (y>>2)*FB_W + (x>>2).
  - When FB_W = 160, the multiply is implemented as shift-add: (y>>2)<<7 + (y>>2)<<5.
  - When `video_on` = 0, register `fb_addr` = 0 so the address never goes out of range.
- **Stage 2 (memory).** `fb_data` is valid this cycle. It is a pass-through and is not registered inside the block.
- **Stage 3 (palette).** Register {VGA_R,VGA_G,VGA_B} = palette[`fb_data`] when the stage-2 video_on is 1; otherwise 0.
- **Sync alignment.** `hsync_in`, `vsync_in` and `video_on` each pass through a 3-stage shift register, matching the colour latency.
- **Palette storage.** 16x12-bit register file with one write port.
  - On reset, entry i loads {i,i,i} (a grayscale ramp).
  - When `pal_we` = 1, the entry `pal_idx` updates at the next edge.
  - A read of the same entry in the same cycle as the write returns the old value.
  - Palette writes are accepted at any time, including during active video. Tearing is acceptable.
- **Arithmetic.** The address sum is computed at ADDR_W bits with no wrap for valid input. The maximum address is 119*160+159 = 19199.

## Timing
- Pixel (x,y) presented at cycle N:
  - its address appears on `fb_addr` at N+1;
  - its colour and its aligned HS/VS appear at N+3.
- The fixed latency is 3 cycles. There is no stall and no backpressure.
- **Reset values.** `fb_addr` = 0. `VGA_R`/`VGA_G`/`VGA_B` = 0. `HS` = `VS` = 1 (inactive). The delay lines fill with video_on = 0 and sync = 1. The palette loads the grayscale ramp.
- **Reset asserted mid-frame.** Takes effect on the next edge. For the 3 cycles after deassertion, outputs stay black with HS/VS inactive, until the delay lines refill from live inputs.
- **Frame boundaries.** No state carries over between lines or frames. Only the palette is persistent.

## Structure
- Shared package `vga_pkg` holds:
  - `FB_W`, `FB_H`, `FB_SCALE_SH` = 2, `PIPE_LAT` = 3;
  - the `rgb12_t` typedef, {r,g,b} nibbles.
- Sub-module `vga_palette`: 16x12 register file with synchronous reset to the ramp, one write port and one asynchronous read port.
- The top level of this block contains the address stage and the delay lines.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with any inputs → `HS`=`VS`=1, RGB=0, `fb_addr`=0, palette[5] reads 0x555.
- **Address mapping.** Drive x=13, y=9, `video_on`=1 → `fb_addr`=2*160+3=323 one cycle later. Drive x=639, y=479 → 19199.
- **Latency and alignment.** Memory model returns index 7 for every address; `hsync_in` falls at cycle N → `HS` falls at N+3, coinciding with RGB=0x777 for a visible pixel.
- **Blanking.** `video_on`=0 with x=700 → `fb_addr`=0, and 3 cycles later RGB=0.
- **Palette write.** `pal_we`=1, `pal_idx`=3, `pal_data`=0xF00 in the same cycle as a stage-3 lookup of index 3 → that pixel shows 0x333 and the next pixel with index 3 shows 0xF00.
- **Mid-frame reset.** Pulse `reset` for 1 cycle during active video → next 3 outputs are black with `HS`=`VS`=1. Normal, aligned output resumes on the 4th cycle and the palette is back to the ramp.
